// File: rtl/mc_ctl.sv
// mc_ctl: multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a memory
// ready timeout and interrupts taken at instruction boundaries. Option macro: ILLOP_TRAP_EN.
module mc_ctl #(
    parameter int N_IRQ        = 4,
    parameter int ALUOP_W      = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_IRQ-1:0]   irq,
    input  logic [N_IRQ-1:0]   irq_mask,
    input  logic               supervisorBit,
    input  logic [5:0]         opCode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic               ALUSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               MemToReg,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ASel,
    output logic               Branch,
    output logic               BranchControl,
    output logic [1:0]         Jump,
    output logic               illOp,
    output logic               bus_err,
    output logic [N_IRQ-1:0]   irq_ack,
    output logic [2:0]         state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_ALU_R = 4'd1;
    localparam logic [3:0] C_SHIFT = 4'd2;
    localparam logic [3:0] C_ALU_I = 4'd3;
    localparam logic [3:0] C_LW    = 4'd4;
    localparam logic [3:0] C_SW    = 4'd5;
    localparam logic [3:0] C_J     = 4'd6;
    localparam logic [3:0] C_JR    = 4'd7;
    localparam logic [3:0] C_JAL   = 4'd8;
    localparam logic [3:0] C_BEQ   = 4'd9;
    localparam logic [3:0] C_BNE   = 4'd10;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(5'b00000);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(5'b00001);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5'b00111);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5'b01000);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(5'b01001);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(5'b01011);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(5'b10001);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5'b10110);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(5'b11000);
    localparam logic [ALUOP_W-1:0] ALU_LINK = ALUOP_W'(5'b11010);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(5'b11110);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

`ifdef ILLOP_TRAP_EN
    localparam bit ILL_TRAP = 1'b1;
`else
    localparam bit ILL_TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]         cls;
        logic [1:0]         regdst;
        logic               alusrc;
        logic               asel;
        logic [ALUOP_W-1:0] aluop;
    } dec_t;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    dec_t              dec_q, dec_d;
    logic              dec_ill;
    logic [N_IRQ-1:0]  pending, irq_lowest;
    logic              take_irq, timed_out, at_boundary;

    assign pending    = irq & ~irq_mask;
    assign irq_lowest = pending & (~pending + N_IRQ'(1));
    assign take_irq   = (|pending) && !supervisorBit;
    assign timed_out  = (wait_q == WAIT_LIMIT);
    assign state      = state_q;

    // Unrecognised encodings leave dec_d all-zero, which executes as a no-op.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dec_d   = '0;
        dec_ill = 1'b0;
        case (opCode)
            6'b000000: begin
                dec_d.cls = C_ALU_R;
                case (funct)
                    6'b000000: begin dec_d.cls = C_SHIFT; dec_d.alusrc = 1'b1; dec_d.aluop = ALU_SLL; end
                    6'b000010: begin dec_d.cls = C_SHIFT; dec_d.alusrc = 1'b1; dec_d.aluop = ALU_SRL; end
                    6'b000011: begin dec_d.cls = C_SHIFT; dec_d.alusrc = 1'b1; dec_d.aluop = ALU_SRA; end
                    6'b100000: dec_d.aluop = ALU_ADD;
                    6'b100010: dec_d.aluop = ALU_SUB;
                    6'b100100: dec_d.aluop = ALU_AND;
                    6'b100101: dec_d.aluop = ALU_OR;
                    6'b100110: dec_d.aluop = ALU_XOR;
                    6'b100111: dec_d.aluop = ALU_NOR;
                    6'b101010: dec_d.aluop = ALU_SLT;
                    6'b001000: dec_d.cls = C_JR;
                    default: begin dec_d.cls = C_NOP; dec_ill = 1'b1; end
                endcase
            end
            6'b000010: dec_d.cls = C_J;
            6'b000011: begin
                dec_d.cls    = C_JAL;
                dec_d.regdst = 2'b11;
                dec_d.asel   = 1'b1;
                dec_d.aluop  = ALU_LINK;
            end
            6'b000100: begin dec_d.cls = C_BEQ; dec_d.aluop = ALU_SUB; end
            6'b000101: begin dec_d.cls = C_BNE; dec_d.aluop = ALU_SUB; end
            6'b001000, 6'b001100, 6'b001101, 6'b001110: begin
                dec_d.cls    = C_ALU_I;
                dec_d.regdst = 2'b01;
                dec_d.alusrc = 1'b1;
                case (opCode[1:0])
                    2'b00:   dec_d.aluop = (opCode[2]) ? ALU_AND : ALU_ADD;
                    2'b01:   dec_d.aluop = ALU_OR;
                    default: dec_d.aluop = ALU_XOR;
                endcase
            end
            6'b100011: begin dec_d.cls = C_LW; dec_d.alusrc = 1'b1; dec_d.aluop = ALU_ADD; end
            6'b101011: begin dec_d.cls = C_SW; dec_d.alusrc = 1'b1; dec_d.aluop = ALU_ADD; end
            default:   dec_ill = 1'b1;
        endcase
    end

    // Outputs are forced low while reset is high so an in-flight access drops at once.
    always_comb begin
        state_d       = state_q;
        at_boundary   = 1'b0;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 2'b00;
        ALUSrc        = 1'b0;
        RegWrite      = 1'b0;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        MemToReg      = 1'b0;
        ALUOp         = '0;
        ASel          = 1'b0;
        Branch        = 1'b0;
        BranchControl = 1'b0;
        Jump          = 2'b00;
        illOp         = 1'b0;
        bus_err       = 1'b0;
        irq_ack       = '0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    if (timed_out) begin
                        bus_err = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        MemRead = 1'b1;
                        if (mem_ready) begin
                            IRWrite = 1'b1;
                            PCWrite = 1'b1;
                            ALUOp   = ALU_ADD;
                            state_d = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (ILL_TRAP && dec_ill) begin
                        illOp   = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    RegDst = dec_q.regdst;
                    ALUSrc = dec_q.alusrc;
                    ASel   = dec_q.asel;
                    ALUOp  = dec_q.aluop;
                    case (dec_q.cls)
                        C_J:   begin Jump = 2'b01; PCWrite = 1'b1; at_boundary = 1'b1; end
                        C_JR:  begin Jump = 2'b10; PCWrite = 1'b1; at_boundary = 1'b1; end
                        C_BEQ: begin Branch = 1'b1; PCWrite = 1'b1; at_boundary = 1'b1; end
                        C_BNE: begin
                            Branch        = 1'b1;
                            BranchControl = 1'b1;
                            PCWrite       = 1'b1;
                            at_boundary   = 1'b1;
                        end
                        C_JAL: begin Jump = 2'b01; PCWrite = 1'b1; state_d = S_WB; end
                        C_LW, C_SW:                 state_d = S_MEM;
                        C_ALU_R, C_SHIFT, C_ALU_I:  state_d = S_WB;
                        default:                    at_boundary = 1'b1;
                    endcase
                end
                S_MEM: begin
                    if (timed_out) begin
                        bus_err = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        MemRead  = (dec_q.cls == C_LW);
                        MemWrite = (dec_q.cls == C_SW);
                        if (mem_ready) begin
                            if (dec_q.cls == C_LW) state_d = S_WB;
                            else                   at_boundary = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    RegWrite    = 1'b1;
                    RegDst      = dec_q.regdst;
                    ALUSrc      = dec_q.alusrc;
                    ASel        = dec_q.asel;
                    ALUOp       = dec_q.aluop;
                    at_boundary = 1'b1;
                    if (dec_q.cls == C_LW) begin
                        MemToReg = 1'b1;
                        RegDst   = 2'b01;
                    end
                end
                S_TRAP: begin
                    RegDst   = 2'b10;
                    RegWrite = 1'b1;
                    ALUOp    = ALU_LINK;
                    ASel     = 1'b1;
                    PCWrite  = 1'b1;
                    state_d  = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
            if (at_boundary) begin
                if (take_irq) begin
                    irq_ack = irq_lowest;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_comb begin
        wait_d = '0;
        if ((state_d == state_q) && !mem_ready && (state_q == S_FETCH || state_q == S_MEM))
            wait_d = wait_q + WAIT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE)
                dec_q <= dec_d;
        end
    end

endmodule

// File: tb/tb_mc_ctl.sv
// Directed self-checking bench for mc_ctl: inputs change on the falling edge,
// outputs are sampled 1 ns later, each step compared to hand-computed values.
module tb_mc_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq, irq_mask;
    logic       supervisorBit;
    logic [5:0] opCode, funct;
    logic       mem_ready;
    logic       PCWrite, IRWrite, ALUSrc, RegWrite, MemWrite, MemRead, MemToReg;
    logic [1:0] RegDst, Jump;
    logic [4:0] ALUOp;
    logic       ASel, Branch, BranchControl, illOp, bus_err;
    logic [3:0] irq_ack;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

`ifdef ILLOP_TRAP_EN
    localparam bit ILL_EXP = 1'b1;
`else
    localparam bit ILL_EXP = 1'b0;
`endif

    mc_ctl #(.N_IRQ(4), .ALUOP_W(5), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask),
        .supervisorBit(supervisorBit), .opCode(opCode), .funct(funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
        .ALUOp(ALUOp), .ASel(ASel), .Branch(Branch),
        .BranchControl(BranchControl), .Jump(Jump), .illOp(illOp),
        .bus_err(bus_err), .irq_ack(irq_ack), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Completes one FETCH with an immediate ready; returns sampled in DECODE.
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        opCode = op; funct = fn; mem_ready = 1'b1;
        #1;
        check("fetch_state", state, 0);
        check("fetch_irwrite", IRWrite, 1);
        check("fetch_pcwrite", PCWrite, 1);
        check("fetch_ack", irq_ack, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("decode_state", state, 1);
        check("decode_ack", irq_ack, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int mr_cnt, mw_cnt, be_cnt;
        logic [3:0] ack_or;

        reset = 1'b1; irq = '0; irq_mask = '0; supervisorBit = 1'b0;
        opCode = '0; funct = '0; mem_ready = 1'b0;
        @(negedge clk); #1;
        check("rst_state", state, 0);
        check("rst_memread", MemRead, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_regwrite", RegWrite, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("fetch_wait_memread", MemRead, 1);
        check("fetch_wait_irwrite", IRWrite, 0);

        // add: FETCH, DECODE, EXEC, WB, FETCH
        fetch(6'b000000, 6'b100000);
        check("add_dec_regwrite", RegWrite, 0);
        @(negedge clk); #1;
        check("add_exec_state", state, 2);
        check("add_exec_aluop", ALUOp, 5'b00000);
        check("add_exec_regwrite", RegWrite, 0);
        @(negedge clk); #1;
        check("add_wb_state", state, 4);
        check("add_wb_regwrite", RegWrite, 1);
        check("add_wb_regdst", RegDst, 2'b00);
        @(negedge clk); #1;
        check("add_done_state", state, 0);
        check("add_done_regwrite", RegWrite, 0);

        // lw with ready delayed 3 cycles in MEM
        fetch(6'b100011, 6'b000000);
        @(negedge clk); #1;
        check("lw_exec_state", state, 2);
        check("lw_exec_alusrc", ALUSrc, 1);
        mr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 3);
            #1;
            check("lw_mem_state", state, 3);
            check("lw_mem_buserr", bus_err, 0);
            if (MemRead) mr_cnt++;
        end
        check("lw_memread_cycles", mr_cnt, 4);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("lw_wb_state", state, 4);
        check("lw_wb_memtoreg", MemToReg, 1);
        check("lw_wb_regdst", RegDst, 2'b01);
        check("lw_wb_regwrite", RegWrite, 1);
        check("lw_wb_memread", MemRead, 0);
        @(negedge clk); #1;
        check("lw_done_state", state, 0);

        // sw never ready: 15 write cycles, one bus_err, trap wins over a pending irq
        fetch(6'b101011, 6'b000000);
        @(negedge clk);
        irq = 4'b0001;
        #1;
        check("sw_exec_state", state, 2);
        mw_cnt = 0; be_cnt = 0; ack_or = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            check("sw_mem_state", state, 3);
            if (MemWrite) mw_cnt++;
            if (bus_err) be_cnt++;
            ack_or = ack_or | irq_ack;
        end
        check("sw_memwrite_cycles", mw_cnt, 15);
        check("sw_buserr_pulses", be_cnt, 1);
        check("sw_no_ack", ack_or, 0);
        @(negedge clk);
        irq = '0;
        #1;
        check("sw_trap_state", state, 5);
        check("sw_trap_regdst", RegDst, 2'b10);
        check("sw_trap_asel", ASel, 1);
        check("sw_trap_regwrite", RegWrite, 1);
        check("sw_trap_pcwrite", PCWrite, 1);
        check("sw_trap_aluop", ALUOp, 5'b11010);
        check("sw_trap_buserr", bus_err, 0);
        @(negedge clk); #1;
        check("sw_done_state", state, 0);

        // addi with irq raised in EXEC: taken only at the WB boundary
        fetch(6'b001000, 6'b000000);
        @(negedge clk);
        irq = 4'b0110;
        #1;
        check("addi_exec_state", state, 2);
        check("addi_exec_regdst", RegDst, 2'b01);
        check("addi_exec_alusrc", ALUSrc, 1);
        check("addi_exec_ack", irq_ack, 0);
        @(negedge clk); #1;
        check("addi_wb_state", state, 4);
        check("addi_wb_ack", irq_ack, 4'b0010);
        @(negedge clk);
        irq = '0;
        #1;
        check("addi_trap_state", state, 5);
        check("addi_trap_ack", irq_ack, 0);
        @(negedge clk); #1;
        check("addi_trap_done", state, 0);

        // same with supervisorBit set: no trap
        supervisorBit = 1'b1;
        fetch(6'b001000, 6'b000000);
        @(negedge clk);
        irq = 4'b0110;
        #1;
        @(negedge clk); #1;
        check("sup_wb_state", state, 4);
        check("sup_wb_ack", irq_ack, 0);
        @(negedge clk); #1;
        check("sup_next_state", state, 0);
        supervisorBit = 1'b0;

        // j with line 1 masked: pending before fetch, acked at the EXEC boundary
        irq_mask = 4'b0010;
        fetch(6'b000010, 6'b000000);
        @(negedge clk); #1;
        check("j_exec_jump", Jump, 2'b01);
        check("j_exec_pcwrite", PCWrite, 1);
        check("j_exec_ack", irq_ack, 4'b0100);
        @(negedge clk);
        irq = '0; irq_mask = '0;
        #1;
        check("j_trap_state", state, 5);
        @(negedge clk); #1;
        check("j_done_state", state, 0);

        // bne completes in EXEC
        fetch(6'b000101, 6'b000000);
        @(negedge clk); #1;
        check("bne_branch", Branch, 1);
        check("bne_bctl", BranchControl, 1);
        check("bne_pcwrite", PCWrite, 1);
        check("bne_aluop", ALUOp, 5'b00001);
        @(negedge clk); #1;
        check("bne_done_state", state, 0);

        // jal: link in EXEC, register write in WB
        fetch(6'b000011, 6'b000000);
        @(negedge clk); #1;
        check("jal_exec_jump", Jump, 2'b01);
        check("jal_exec_regdst", RegDst, 2'b11);
        check("jal_exec_asel", ASel, 1);
        check("jal_exec_aluop", ALUOp, 5'b11010);
        @(negedge clk); #1;
        check("jal_wb_state", state, 4);
        check("jal_wb_regwrite", RegWrite, 1);
        check("jal_wb_regdst", RegDst, 2'b11);
        check("jal_wb_pcwrite", PCWrite, 0);
        @(negedge clk); #1;
        check("jal_done_state", state, 0);

        // sll uses the shift-amount operand
        fetch(6'b000000, 6'b000000);
        @(negedge clk); #1;
        check("sll_exec_alusrc", ALUSrc, 1);
        check("sll_exec_aluop", ALUOp, 5'b01000);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("sll_done_state", state, 0);

        // reset mid-MEM of lw, then a long FETCH wait must not time out
        fetch(6'b100011, 6'b000000);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
        end
        check("rmem_state", state, 3);
        check("rmem_memread", MemRead, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rmem_rst_memread", MemRead, 0);
        check("rmem_rst_state", state, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rmem_refetch_memread", MemRead, 1);
        be_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (bus_err) be_cnt++;
        end
        check("rmem_fetch_no_buserr", be_cnt, 0);
        fetch(6'b000000, 6'b100000);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rmem_done_state", state, 0);

        // illegal opcode
        fetch(6'b111111, 6'b000000);
        check("ill_decode_illop", illOp, ILL_EXP);
        @(negedge clk); #1;
        check("ill_next_state", state, ILL_EXP ? 5 : 2);
        check("ill_next_illop", illOp, 0);
        if (!ILL_EXP) begin
            check("ill_nop_regwrite", RegWrite, 0);
            check("ill_nop_pcwrite", PCWrite, 0);
        end
        @(negedge clk); #1;
        check("ill_done_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
